// File: rtl/rsa_rfid_pkg.sv
// ----------------------------------------------------------------------------
// rsa_rfid_pkg : shared width default, FSM encoding and latency     rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rsa_rfid_pkg;

  localparam int c_default_width = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    EXP    = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int calc_latency(input int w);
    return 1 + w + w * w;
  endfunction

  localparam int c_latency = calc_latency(c_default_width);

endpackage

`default_nettype wire

// File: rtl/rsa_modmul.sv
// ----------------------------------------------------------------------------
// rsa_modmul : interleaved shift-add modular multiplier, a*b mod n   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rsa_modmul
  import rsa_rfid_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;

  logic [WIDTH-1:0] w_acc_in;
  logic             w_bit;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_n;
  logic [WIDTH-1:0] w_red;
  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_sum;

  // The load cycle is also the first step, so an op takes exactly WIDTH enabled cycles.
  always_comb begin
    w_acc_in = load ? '0 : r_acc;
    w_bit    = load ? b[WIDTH-1] : r_sh[WIDTH-1];
    w_n      = {1'b0, n};
    w_dbl    = {w_acc_in, 1'b0};
    w_red    = (w_dbl >= w_n) ? (w_dbl[WIDTH-1:0] - n) : w_dbl[WIDTH-1:0];
    w_add    = w_bit ? ({1'b0, w_red} + {1'b0, a}) : {1'b0, w_red};
    w_sum    = (w_add >= w_n) ? (w_add[WIDTH-1:0] - n) : w_add[WIDTH-1:0];
  end

  // Combinational so the owner can capture the result on the final step's edge.
  assign product = w_sum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
      r_sh  <= '0;
    end else if (en) begin
      r_acc <= w_sum;
      r_sh  <= load ? {b[WIDTH-2:0], 1'b0} : {r_sh[WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/rsa_rfid.sv
// ----------------------------------------------------------------------------
// rsa_rfid : sequential modular exponentiation M^E mod N (LSB-first) rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rsa_rfid
  import rsa_rfid_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_text,
  input  logic [WIDTH-1:0] key,
  input  logic [WIDTH-1:0] mod,
  output logic [WIDTH-1:0] output_text,
  input  logic             go,
  output logic             done
);

  localparam int               c_cw    = $clog2(WIDTH);
  localparam logic [c_cw-1:0]  c_last  = c_cw'(WIDTH - 1);
  localparam logic [c_cw:0]    c_nbits = (c_cw + 1)'(WIDTH);
  localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_b;
  logic [c_cw-1:0]  r_cnt;
  logic [c_cw:0]    r_kbit;

  logic             w_capture;
  logic             w_load;
  logic             w_op_last;
  logic             w_exp_run;
  logic             w_sq_en;
  logic             w_mul_en;
  logic [WIDTH-1:0] w_sq_a;
  logic [WIDTH-1:0] w_sq_b;
  logic [WIDTH-1:0] w_sq_prod;
  logic [WIDTH-1:0] w_mul_prod;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_load       = (r_cnt == '0);
    w_op_last    = (r_cnt == c_last);
    w_exp_run    = (r_kbit != c_nbits);
    w_sq_en      = 1'b0;
    w_mul_en     = 1'b0;
    w_sq_a       = r_b;
    w_sq_b       = r_b;
    case (r_state)
      IDLE, DONE: begin
        if (go) begin
          w_capture    = 1'b1;
          w_state_next = REDUCE;
        end
      end
      REDUCE: begin
        // B = 1*M mod N with M as multiplier, so M >= N needs no pre-reduction.
        w_sq_en = 1'b1;
        w_sq_a  = c_one;
        w_sq_b  = r_m;
        if (w_op_last) w_state_next = EXP;
      end
      EXP: begin
        w_sq_en  = w_exp_run;
        w_mul_en = w_exp_run;
        if (!w_exp_run) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .en      (w_mul_en),
    .a       (r_r),
    .b       (r_b),
    .n       (r_n),
    .product (w_mul_prod)
  );

  rsa_modmul #(.WIDTH(WIDTH)) u_sq (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .en      (w_sq_en),
    .a       (w_sq_a),
    .b       (w_sq_b),
    .n       (r_n),
    .product (w_sq_prod)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_m         <= '0;
      r_e         <= '0;
      r_n         <= '0;
      r_r         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_kbit      <= '0;
      output_text <= '0;
      done        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_m    <= input_text;
        r_e    <= key;
        r_n    <= mod;
        r_cnt  <= '0;
        r_kbit <= '0;
        done   <= 1'b0;
      end
      case (r_state)
        REDUCE: begin
          r_cnt <= w_op_last ? '0 : r_cnt + c_cw'(1);
          if (w_load) r_r <= (r_n > c_one) ? c_one : '0;
          if (w_op_last) r_b <= w_sq_prod;
        end
        EXP: begin
          if (w_exp_run) begin
            r_cnt <= w_op_last ? '0 : r_cnt + c_cw'(1);
            if (w_op_last) begin
              if (r_e[0]) r_r <= w_mul_prod;
              r_b    <= w_sq_prod;
              r_e    <= r_e >> 1;
              r_kbit <= r_kbit + (c_cw + 1)'(1);
            end
          end else begin
            // N = 0 has no meaningful residue; it reports 0 like N = 1.
            output_text <= (r_n == '0) ? '0 : r_r;
            done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rsa_rfid.sv
// ----------------------------------------------------------------------------
// tb_rsa_rfid : directed vector bench for rsa_rfid                   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rsa_rfid;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] input_text;
  logic [31:0] key;
  logic [31:0] mod;
  logic [31:0] output_text;
  logic        go;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] m;
    logic [31:0] e;
    logic [31:0] n;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[10];

  rsa_rfid #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .input_text  (input_text),
    .key         (key),
    .mod         (mod),
    .output_text (output_text),
    .go          (go),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain square-and-multiply with the % operator as an independent reference.
  function automatic logic [31:0] modexp(input logic [31:0] m, input logic [31:0] e,
                                         input logic [31:0] n);
    logic [63:0] r;
    logic [63:0] b;
    if (n == 0) return 32'd0;
    r = 64'd1 % n;
    b = m % n;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r[31:0];
  endfunction

  // Entered #1 after an edge; returns #1 after the done (or reset) edge.
  task automatic run(input string nm, input logic [31:0] m, input logic [31:0] e,
                     input logic [31:0] n, input logic [31:0] exp,
                     input int glitch_at, input int rst_at);
    logic [31:0] prev;
    bit          held;
    int          lat;
    prev       = output_text;
    held       = 1'b1;
    lat        = 0;
    input_text = m;
    key        = e;
    mod        = n;
    go         = 1'b1;
    @(posedge clk); #1;
    go         = 1'b0;
    input_text = $urandom;
    key        = $urandom;
    mod        = $urandom;
    check({nm, "_done_drop"}, done, 0);
    for (int c = 1; c <= 2000; c++) begin
      go = (c == glitch_at);
      if (c == glitch_at) begin
        input_text = 32'd9;
        key        = 32'd2;
        mod        = 32'd11;
      end
      reset = (c == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      if (c == rst_at) begin
        check({nm, "_rst_done"}, done, 0);
        check({nm, "_rst_out"}, output_text, 0);
        return;
      end
      if (done) begin
        lat = c;
        break;
      end
      if (output_text !== prev) held = 1'b0;
    end
    check({nm, "_latency"}, lat, 1057);
    check({nm, "_result"}, output_text, exp);
    check({nm, "_out_stable"}, held, 1);
  endtask

  initial begin
    logic [31:0] ref_big;
    bit          ok_done;
    bit          ok_out;

    vecs[0] = '{32'd4,        32'd13,       32'd497,      32'd445};
    vecs[1] = '{32'd5,        32'd0,        32'd13,       32'd1};
    vecs[2] = '{32'd600,      32'd3,        32'd13,       32'd8};
    vecs[3] = '{32'd7,        32'd5,        32'd1,        32'd0};
    vecs[4] = '{32'd7,        32'd5,        32'd0,        32'd0};
    vecs[5] = '{32'd0,        32'd5,        32'd13,       32'd0};
    vecs[6] = '{32'd2,        32'd10,       32'd1000,     32'd24};
    vecs[7] = '{32'd2,        32'd31,       32'hFFFFFFFF, 32'h80000000};
    vecs[8] = '{32'd2,        32'd32,       32'hFFFFFFFF, 32'd1};
    vecs[9] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd1};

    reset      = 1'b0;
    go         = 1'b0;
    input_text = 32'd4;
    key        = 32'd13;
    mod        = 32'd497;
    repeat (2) @(posedge clk);
    #1 go = 1'b1;
    @(posedge clk); #1;
    check("reset_done", done, 0);
    check("reset_out", output_text, 0);
    go = 1'b0;

    // First go accepted on the very first edge with reset released.
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run($sformatf("vec%0d", i), vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].r, 0, 0);
    end

    ok_done = 1'b1;
    ok_out  = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done !== 1'b1) ok_done = 1'b0;
      if (output_text !== 32'h1) ok_out = 1'b0;
    end
    check("hold_done", ok_done, 1);
    check("hold_out", output_text, 32'h1);
    check("hold_out_all", ok_out, 1);

    ref_big = modexp(32'h00982af2, 32'ha51126c1, 32'hae177305);
    run("big", 32'h00982af2, 32'ha51126c1, 32'hae177305, ref_big, 0, 0);
    run("b2b", 32'd600, 32'd3, 32'd13, 32'd8, 0, 0);
    run("glitch", 32'd4, 32'd13, 32'd497, 32'd445, 300, 0);

    run("abort", 32'h00982af2, 32'ha51126c1, 32'hae177305, ref_big, 0, 500);
    reset   = 1'b1;
    ok_done = 1'b1;
    repeat (1100) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || output_text !== 32'd0) ok_done = 1'b0;
    end
    check("abort_quiet", ok_done, 1);
    run("after_abort", 32'd4, 32'd13, 32'd497, 32'd445, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
